// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings used by both Tx and Rx, Tx state encoding.
package uart_pkg;

  localparam logic [1:0] NOPARITY00 = 2'b00;
  localparam logic [1:0] ODD        = 2'b01;
  localparam logic [1:0] EVEN       = 2'b10;
  localparam logic [1:0] NOPARITY11 = 2'b11;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  function automatic logic parity_enabled(input logic [1:0] ptype);
    return (ptype == ODD) || (ptype == EVEN);
  endfunction

  // EVEN makes the ones-count over data+parity even, ODD makes it odd.
  function automatic logic parity_bit(input logic [1:0] ptype, input logic [7:0] data);
    return (ptype == ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick marks the last cycle of each CLKS_PER_BIT-cycle bit period.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // A clear restarts the period, so the wrap in that cycle must not count.
  assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  output logic       tx_out,
  output logic       tx_active,
  output logic       tx_done
);

  tx_state_t  state;
  logic [7:0] data_q;
  logic       par_en_q;
  logic       par_bit_q;
  logic       two_stop_q;
  logic [2:0] bit_idx;
  logic       stop_idx;
  logic       tick;
  logic       accept;

  assign accept = tx_valid && tx_ready;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock(clock),
    .reset(reset),
    .clear(accept),
    .tick (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= TX_IDLE;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      tx_out     <= 1'b1;
      tx_ready   <= 1'b1;
      tx_active  <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        TX_IDLE: begin
          if (accept) begin
            data_q     <= tx_data;
            par_en_q   <= parity_enabled(parity_type);
            par_bit_q  <= parity_bit(parity_type, tx_data);
            two_stop_q <= stop_bits;
            state      <= TX_START;
            tx_out     <= 1'b0;
            tx_ready   <= 1'b0;
            tx_active  <= 1'b1;
          end
        end
        TX_START: begin
          if (tick) begin
            state   <= TX_DATA;
            bit_idx <= '0;
            tx_out  <= data_q[0];
          end
        end
        TX_DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
              stop_idx <= 1'b0;
              if (par_en_q) begin
                state  <= TX_PARITY;
                tx_out <= par_bit_q;
              end else begin
                state  <= TX_STOP;
                tx_out <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_out  <= data_q[bit_idx + 3'd1];
            end
          end
        end
        TX_PARITY: begin
          if (tick) begin
            state  <= TX_STOP;
            tx_out <= 1'b1;
          end
        end
        TX_STOP: begin
          if (tick) begin
            if (two_stop_q && !stop_idx) begin
              stop_idx <= 1'b1;
            end else begin
              state     <= TX_IDLE;
              tx_ready  <= 1'b1;
              tx_active <= 1'b0;
              tx_done   <= 1'b1;
            end
          end
        end
        default: begin
          state     <= TX_IDLE;
          tx_out    <= 1'b1;
          tx_ready  <= 1'b1;
          tx_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame at CLKS_PER_BIT=4 and CLKS_PER_BIT=1.
module tb_uart_tx_frame;

  localparam logic [1:0] P_NONE00 = 2'b00;
  localparam logic [1:0] P_ODD    = 2'b01;
  localparam logic [1:0] P_EVEN   = 2'b10;
  localparam logic [1:0] P_NONE11 = 2'b11;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic       valid4, valid1;
  logic       ready4, ready1;
  logic       out4, out1;
  logic       active4, active1;
  logic       done4, done1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  uart_tx_frame #(.CLKS_PER_BIT(4)) dut4 (
    .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(valid4),
    .tx_ready(ready4), .parity_type(parity_type), .stop_bits(stop_bits),
    .tx_out(out4), .tx_active(active4), .tx_done(done4)
  );

  uart_tx_frame #(.CLKS_PER_BIT(1)) dut1 (
    .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(valid1),
    .tx_ready(ready1), .parity_type(parity_type), .stop_bits(stop_bits),
    .tx_out(out1), .tx_active(active1), .tx_done(done1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks every cycle of a frame starting at the current negedge (first start-bit cycle),
  // then the tx_done cycle; returns at the negedge of the cycle after tx_done.
  task automatic run_frame(input bit sel, input string bits, input int cpb,
                           input int change_at, input string tag);
    int cyc;
    logic exp_bit;
    cyc = 0;
    for (int b = 0; b < bits.len(); b++) begin
      exp_bit = (bits[b] == "1");
      for (int c = 0; c < cpb; c++) begin
        check($sformatf("%s out b%0d c%0d", tag, b, c), sel ? out1 : out4, exp_bit);
        check($sformatf("%s active b%0d", tag, b), sel ? active1 : active4, 1);
        check($sformatf("%s ready b%0d", tag, b), sel ? ready1 : ready4, 0);
        check($sformatf("%s done b%0d", tag, b), sel ? done1 : done4, 0);
        if (cyc == change_at) begin
          tx_data     = 8'hFF;
          parity_type = P_ODD;
          stop_bits   = 1'b1;
        end
        cyc++;
        @(negedge clock);
      end
    end
    check({tag, " done pulse"}, sel ? done1 : done4, 1);
    check({tag, " done ready"}, sel ? ready1 : ready4, 1);
    check({tag, " done active"}, sel ? active1 : active4, 0);
    check({tag, " done out"}, sel ? out1 : out4, 1);
    @(negedge clock);
  endtask

  initial begin
    bit done_seen;
    reset = 1'b1; valid4 = 1'b0; valid1 = 1'b0;
    tx_data = 8'h00; parity_type = P_NONE00; stop_bits = 1'b0;
    repeat (3) @(negedge clock);
    check("rst out4", out4, 1);     check("rst ready4", ready4, 1);
    check("rst active4", active4, 0); check("rst done4", done4, 0);
    check("rst out1", out1, 1);     check("rst ready1", ready1, 1);
    check("rst active1", active1, 0); check("rst done1", done1, 0);
    reset = 1'b0;
    @(negedge clock);

    // 0xA5, EVEN, one stop: parity 0, tx_done 45 cycles after handshake
    tx_data = 8'hA5; parity_type = P_EVEN; stop_bits = 1'b0; valid4 = 1'b1;
    @(negedge clock);
    valid4 = 1'b0;
    run_frame(0, "01010010101", 4, -1, "even");
    check("even after done", done4, 0);
    check("even after ready", ready4, 1);

    // 0x07, ODD, two stops
    tx_data = 8'h07; parity_type = P_ODD; stop_bits = 1'b1; valid4 = 1'b1;
    @(negedge clock);
    valid4 = 1'b0;
    run_frame(0, "011100000011", 4, -1, "odd2stop");
    check("odd2stop idle out", out4, 1);

    // 0x00, parity 11: no parity bit
    tx_data = 8'h00; parity_type = P_NONE11; stop_bits = 1'b0; valid4 = 1'b1;
    @(negedge clock);
    valid4 = 1'b0;
    run_frame(0, "0000000001", 4, -1, "nopar");
    check("nopar idle ready", ready4, 1);

    // Back-to-back 0x55 then 0xAA, valid held high throughout
    tx_data = 8'h55; parity_type = P_NONE00; stop_bits = 1'b0; valid4 = 1'b1;
    @(negedge clock);
    tx_data = 8'hAA;
    run_frame(0, "0101010101", 4, -1, "b2b first");
    valid4 = 1'b0;
    run_frame(0, "0010101011", 4, -1, "b2b second");
    check("b2b idle ready", ready4, 1);

    // Inputs change mid-frame; latched byte/parity/stops must be used
    tx_data = 8'h3C; parity_type = P_EVEN; stop_bits = 1'b0; valid4 = 1'b1;
    @(negedge clock);
    valid4 = 1'b0;
    run_frame(0, "00011110001", 4, 10, "stable");
    check("stable idle done", done4, 0);

    // One cycle per bit: 0xFF, EVEN
    tx_data = 8'hFF; parity_type = P_EVEN; stop_bits = 1'b0; valid1 = 1'b1;
    @(negedge clock);
    valid1 = 1'b0;
    run_frame(1, "01111111101", 1, -1, "cpb1");
    check("cpb1 idle ready", ready1, 1);

    // Reset during data bit 3 of 0xA5
    tx_data = 8'hA5; parity_type = P_EVEN; stop_bits = 1'b0; valid4 = 1'b1;
    @(negedge clock);
    valid4 = 1'b0;
    repeat (17) @(negedge clock);
    check("abort pre out", out4, 0);
    check("abort pre active", active4, 1);
    reset = 1'b1;
    @(negedge clock);
    check("abort out", out4, 1);
    check("abort ready", ready4, 1);
    check("abort active", active4, 0);
    check("abort done", done4, 0);
    reset = 1'b0;
    done_seen = 1'b0;
    repeat (60) begin
      @(negedge clock);
      if (done4) done_seen = 1'b1;
    end
    check("abort no done", done_seen, 0);
    check("abort idle out", out4, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Transmit-side UART framer: accepts one 8-bit byte per valid/ready handshake and serialises it as a complete frame on `tx_out`. The frame is a start bit, 8 data bits LSB-first, an optional parity bit and one or two stop bits. It uses the same parity encoding and frame format that the Rx error checker validates. It sits between the host-side byte source and the physical TX pin, and generates its own bit timing from the system clock.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit period; must be ≥ 1.
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `tx_data`  in  8  byte to send; sampled only on handshake.
- `tx_valid`  in  1  byte on `tx_data` is available.
- `tx_ready`  out  1  framer is idle and accepts a byte this cycle.
- `parity_type`  in  2  `01` = ODD, `10` = EVEN, `00`/`11` = no parity; sampled on handshake.
- `stop_bits`  in  1  `0` = one stop bit, `1` = two stop bits; sampled on handshake.
- `tx_out`  out  1  serial line; idles high.
- `tx_active`  out  1  high while a frame is on the line.
- `tx_done`  out  1  one-cycle pulse after the last stop bit completes.

## Operation
- **States:** IDLE → START → DATA → PARITY → STOP → IDLE.
  - PARITY is skipped when `parity_type` is `00` or `11`.
  - STOP lasts 1 or 2 bit periods, per the latched `stop_bits`.
- **Handshake:** a byte is accepted when `tx_valid && tx_ready`. On acceptance, `tx_data`, `parity_type` and `stop_bits` are latched. Later input changes do not affect the frame in flight.
- **`tx_ready`:** high only in IDLE. No internal buffering.
- **Bit values:**
  - START drives 0.
  - DATA drives `data[0]` first through `data[7]`.
  - STOP drives 1.
  - IDLE drives 1.
- **Parity bit** (computed from the latched byte):
  - EVEN: `^data`.
  - ODD: `~^data`.
  - The total count of ones over data+parity is therefore even or odd respectively, matching the Rx check.
- **Bit timer:** counter of width `$clog2(CLKS_PER_BIT)` (minimum 1). Counts 0 … `CLKS_PER_BIT-1`, wraps to 0 and advances the bit/state on wrap. A 3-bit data index advances on each wrap in DATA; DATA exits after index 7 wraps.
- **Reset values:** `tx_out` = 1, `tx_ready` = 1, `tx_active` = 0, `tx_done` = 0; state IDLE; counters 0.
- **Reset mid-frame:** the frame is abandoned at the next edge. `tx_out` returns to 1, and no `tx_done` pulse is issued for the aborted frame.
- `tx_valid` while busy is ignored. The source must hold it until it sees `tx_ready`.

## Timing
- Handshake in cycle N: `tx_out` = 0 (start bit) from cycle N+1. Each bit holds for exactly `CLKS_PER_BIT` cycles.
- **Frame length:** F = 1 + 8 + P + S bits, where P ∈ {0,1} and S ∈ {1,2}. The line is driven by the frame during cycles N+1 … N+F·`CLKS_PER_BIT`.
- **`tx_active`:** high exactly over that span.
- **`tx_ready`:** low over the same span.
- **End of frame:** in cycle N+F·`CLKS_PER_BIT`+1, `tx_done` = 1 for one cycle and `tx_ready` = 1.
- **Back-to-back:** a handshake in the `tx_done` cycle starts the next start bit in the following cycle, with no idle gap.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `CLKS_PER_BIT` = 1 is legal: one bit per cycle.

## Structure
- **Shared package `uart_pkg`:**
  - Parity encodings `ODD` = `2'b01`, `EVEN` = `2'b10`, `NOPARITY00` = `2'b00`, `NOPARITY11` = `2'b11`. The Rx side uses the same constants.
  - Tx state encoding.
- **Sub-module `uart_baud_tick`:** parameterised by `CLKS_PER_BIT`, with inputs `clock`, `reset` and `clear`, and output `tick`, asserted on the wrap cycle. The framer clears it on handshake.
- The parity computation is an inline reduction, not a separate module.

## Test plan
- **Even parity:** `CLKS_PER_BIT`=4, `tx_data`=0xA5, EVEN, one stop bit. Line shows 0,1,0,1,0,0,1,0,1,0(parity),1, each bit 4 cycles. `tx_done` occurs 45 cycles after handshake.
- **Odd parity, two stops:** 0x07, ODD, two stop bits. Data 1,1,1,0,0,0,0,0, parity 0, stop bits 1,1. Frame is 12 bits = 48 cycles.
- **No parity:** `parity_type`=`11`, 0x00. Frame is start, 8 zeros, 1 stop = 10 bits. No parity bit on the line.
- **Back-to-back:** 0x55 then 0xAA, with `tx_valid` held high. The second start bit begins the cycle after the first `tx_done`. `tx_ready` is high for exactly 1 cycle between frames.
- **Reset mid-frame:** assert `reset` during DATA bit 3. Next cycle: `tx_out`=1, `tx_ready`=1, `tx_active`=0. `tx_done` never pulses for that frame.
- **Input stability:** change `tx_data` and `parity_type` mid-frame. The line still carries the latched byte and parity. Also run `CLKS_PER_BIT`=1 with 0xFF, EVEN: 11-cycle frame with parity 0.
